// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - iterative restoring signed divider with start/busy/done handshake
// Optional: define SEQ_DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle after start.
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   dvd_mag;   // |dividend|, kept intact for the divide-by-zero result
  logic [WIDTH-1:0] dvd_sh;    // |dividend| shifted out MSB first during CALC
  logic [WIDTH:0]   dvs_mag;   // |divisor|
  logic [WIDTH:0]   prem;      // partial remainder magnitude
  logic [WIDTH-1:0] qmag;      // quotient magnitude, truncated to WIDTH bits
  logic             qsign;
  logic             rsign;
  logic             zero;

  logic [WIDTH:0]   dividend_abs;
  logic [WIDTH:0]   divisor_abs;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH:0]   prem_next;

  // Operand magnitudes on WIDTH+1 bits so |-2^(WIDTH-1)| is representable
  always_comb begin
    dividend_abs = dividend[WIDTH-1] ? ({1'b0, ~dividend} + (WIDTH+1)'(1)) : {1'b0, dividend};
    divisor_abs  = divisor[WIDTH-1]  ? ({1'b0, ~divisor}  + (WIDTH+1)'(1)) : {1'b0, divisor};
  end

  // One restoring step: shift in next dividend bit, trial subtract, keep or restore
  always_comb begin
    shifted   = {prem[WIDTH-1:0], dvd_sh[WIDTH-1]};
    fits      = (shifted >= dvs_mag);
    prem_next = fits ? (shifted - dvs_mag) : shifted;
  end

  // Control FSM and datapath registers; outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_mag     <= '0;
      dvd_sh      <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      qmag        <= '0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_mag <= dividend_abs;
            dvd_sh  <= dividend_abs[WIDTH-1:0];
            dvs_mag <= divisor_abs;
            prem    <= '0;
            qmag    <= '0;
            qsign   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rsign   <= dividend[WIDTH-1];
            zero    <= (divisor == '0);
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
`ifdef SEQ_DIV_ZERO_FAST_EN
            state   <= (divisor == '0) ? FIX : CALC;
`else
            state   <= CALC;
`endif
          end
        end
        CALC: begin
          prem   <= prem_next;
          qmag   <= {qmag[WIDTH-2:0], fits};
          dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero) begin
            quotient  <= '1;
            remainder <= WIDTH'(rsign ? -dvd_mag : dvd_mag);
          end else begin
            quotient  <= qsign ? -qmag : qmag;
            remainder <= WIDTH'(rsign ? -prem : prem);
          end
          div_by_zero <= zero;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - scoreboard testbench for seq_signed_divider
module tb_seq_signed_divider;

  localparam int W = 8;
`ifdef SEQ_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   qi;
    int   ri;
    if (b == 0) begin
      e.q = '1;
      e.r = W'(a);
      e.z = 1'b1;
    end else begin
      qi  = a / b;
      ri  = a % b;
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic launch(input int a, input int b);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic collect(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int   cyc, bcnt;
    exp_t e;
    launch(100, 7);
    collect(cyc, bcnt);
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL basic_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    checks++;
    if (cyc !== W + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want %0d", cyc, W + 1);
    end
    checks++;
    if (bcnt !== W + 1) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles, want %0d", bcnt, W + 1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || {quotient, remainder} !== {8'd14, 8'd2}) begin
      errors++;
      $display("FAIL basic_hold: got done=%b q=%h r=%h, want done=0 q=0e r=02",
               done, quotient, remainder);
    end
  endtask

  task automatic test_signs;
    int   ta[7] = '{-100, 100, -100, -128, 0, 5, 127};
    int   tb[7] = '{7, -7, -7, -1, 5, 127, -128};
    int   cyc, bcnt;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      launch(ta[i], tb[i]);
      collect(cyc, bcnt);
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, div_by_zero} !== e || cyc !== W + 1) begin
        errors++;
        $display("FAIL signs_%0d/%0d: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                 ta[i], tb[i], quotient, remainder, div_by_zero, cyc, e.q, e.r, e.z, W + 1);
      end
    end
  endtask

  task automatic test_div_zero;
    int   ta[2] = '{5, -128};
    int   cyc, bcnt;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      launch(ta[i], 0);
      collect(cyc, bcnt);
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, div_by_zero} !== e) begin
        errors++;
        $display("FAIL div_zero_result_%0d: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                 ta[i], quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
      checks++;
      if (cyc !== ZLAT || bcnt !== ZLAT) begin
        errors++;
        $display("FAIL div_zero_timing_%0d: got lat=%0d busy=%0d, want %0d", ta[i], cyc, bcnt, ZLAT);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int   cyc, bcnt, extra;
    exp_t e;
    launch(100, 7);
    @(negedge clk);
    dividend = W'(1);
    divisor  = W'(1);
    start    = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    collect(cyc, bcnt);
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e || done !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_result: got done=%b q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
               done, quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_ignore_spurious: got %0d busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int   cyc, bcnt;
    exp_t e;
    launch(20, 3);
    collect(cyc, bcnt);
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL b2b_first: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    dividend = W'(50);
    divisor  = W'(-3);
    start    = 1'b1;
    sb.push_back(model(50, -3));
    @(posedge clk);
    #1;
    start = 1'b0;
    collect(cyc, bcnt);
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL b2b_second: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    checks++;
    if (cyc !== W + 1 || bcnt !== W + 1) begin
      errors++;
      $display("FAIL b2b_gap: got lat=%0d busy=%0d, want %0d", cyc, bcnt, W + 1);
    end
  endtask

  task automatic test_reset_mid;
    int   cyc, bcnt, pulses;
    exp_t e;
    launch(20, 3);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d busy/done cycles, want 0", pulses);
    end
    launch(20, 3);
    collect(cyc, bcnt);
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e || cyc !== W + 1) begin
      errors++;
      $display("FAIL reset_mid_rerun: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
               quotient, remainder, div_by_zero, cyc, e.q, e.r, e.z, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
